// File: rtl/rr_channel_scheduler.sv
// Round-robin scheduler sharing one downstream channel among NUM_CH requesters.
// Request-driven slots with bounded dwell, a one-cycle settle gap, and sticky served flags.
module rr_channel_scheduler #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = 2,
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic [HOLD_W-1:0] hold_len,
    input  logic              served_clr,
    output logic [NUM_CH-1:0] gnt,
    output logic [IDX_W-1:0]  gnt_idx,
    output logic              gnt_valid,
    output logic [NUM_CH-1:0] served
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0]        state;
    logic [IDX_W-1:0]  last_ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_lim;

    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    logic [IDX_W-1:0]  cand;
    logic              release_now;
    logic [NUM_CH-1:0] served_nxt;

    // Search upward from last_ptr+1; IDX_W-bit addition wraps modulo NUM_CH.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            cand = last_ptr + IDX_W'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign release_now = (state == ST_GRANT) &&
                         (!req[gnt_idx] || (hold_cnt == hold_lim));

    // A release set takes priority over a same-cycle clear for its bit.
    always_comb begin
        served_nxt = served_clr ? '0 : served;
        if (release_now) begin
            served_nxt[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            last_ptr  <= IDX_W'(NUM_CH - 1);
            hold_cnt  <= '0;
            hold_lim  <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            served    <= '0;
        end else begin
            served <= served_nxt;
            case (state)
                ST_IDLE, ST_GAP: begin
                    if (win_found) begin
                        state     <= ST_GRANT;
                        gnt       <= {{(NUM_CH-1){1'b0}}, 1'b1} << win_idx;
                        gnt_idx   <= win_idx;
                        gnt_valid <= 1'b1;
                        hold_lim  <= hold_len;
                        hold_cnt  <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (release_now) begin
                        state     <= ST_GAP;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        last_ptr  <= gnt_idx;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    gnt       <= '0;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_channel_scheduler.sv
// Scoreboarded directed bench for rr_channel_scheduler (NUM_CH=4, HOLD_W=4).
module tb_rr_channel_scheduler;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] hold_len;
    logic       served_clr;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic [3:0] served;

    int checks;
    int errors;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] idx;
        logic [3:0] served;
        string      name;
    } exp_t;

    exp_t sb[$];

    rr_channel_scheduler #(
        .NUM_CH(4),
        .IDX_W (2),
        .HOLD_W(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .hold_len  (hold_len),
        .served_clr(served_clr),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .served    (served)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // Monitor: one expected snapshot per clock edge while stimulus is queued.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, ".gnt"},       {4'b0, gnt},        {4'b0, e.gnt});
            chk({e.name, ".gnt_idx"},   {6'b0, gnt_idx},    {6'b0, e.idx});
            chk({e.name, ".gnt_valid"}, {7'b0, gnt_valid},  {7'b0, (e.gnt != 4'b0)});
            chk({e.name, ".served"},    {4'b0, served},     {4'b0, e.served});
        end
    end

    task automatic step(input logic [3:0] r, input logic [3:0] h, input logic c,
                        input logic [3:0] eg, input logic [1:0] ei, input logic [3:0] es,
                        input string nm);
        exp_t e;
        @(negedge clk);
        req        = r;
        hold_len   = h;
        served_clr = c;
        e.gnt    = eg;
        e.idx    = ei;
        e.served = es;
        e.name   = nm;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        req        = '0;
        hold_len   = '0;
        served_clr = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst.gnt",       {4'b0, gnt},       8'h00);
            chk("rst.gnt_idx",   {6'b0, gnt_idx},   8'h00);
            chk("rst.gnt_valid", {7'b0, gnt_valid}, 8'h00);
            chk("rst.served",    {4'b0, served},    8'h00);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        req        = '0;
        hold_len   = '0;
        served_clr = 1'b0;

        // Single requester, hold_len=2: 3 on, 1 gap, repeat
        do_reset();
        for (int k = 0; k < 2; k++) begin
            step(4'b0100, 4'd2, 1'b0, 4'b0100, 2'd2, (k == 0) ? 4'b0000 : 4'b0100, "single.on0");
            step(4'b0100, 4'd2, 1'b0, 4'b0100, 2'd2, (k == 0) ? 4'b0000 : 4'b0100, "single.on1");
            step(4'b0100, 4'd2, 1'b0, 4'b0100, 2'd2, (k == 0) ? 4'b0000 : 4'b0100, "single.on2");
            step(4'b0100, 4'd2, 1'b0, 4'b0000, 2'd2, 4'b0100, "single.gap");
        end
        step(4'b0000, 4'd2, 1'b0, 4'b0000, 2'd2, 4'b0100, "single.idle");
        step(4'b0000, 4'd2, 1'b1, 4'b0000, 2'd2, 4'b0000, "single.clr");

        // Full rotation, hold_len=0: period 8
        do_reset();
        step(4'b1111, 4'd0, 1'b0, 4'b0001, 2'd0, 4'b0000, "rot.g0");
        step(4'b1111, 4'd0, 1'b0, 4'b0000, 2'd0, 4'b0001, "rot.p0");
        step(4'b1111, 4'd0, 1'b0, 4'b0010, 2'd1, 4'b0001, "rot.g1");
        step(4'b1111, 4'd0, 1'b0, 4'b0000, 2'd1, 4'b0011, "rot.p1");
        step(4'b1111, 4'd0, 1'b0, 4'b0100, 2'd2, 4'b0011, "rot.g2");
        step(4'b1111, 4'd0, 1'b0, 4'b0000, 2'd2, 4'b0111, "rot.p2");
        step(4'b1111, 4'd0, 1'b0, 4'b1000, 2'd3, 4'b0111, "rot.g3");
        step(4'b1111, 4'd0, 1'b0, 4'b0000, 2'd3, 4'b1111, "rot.p3");
        step(4'b1111, 4'd0, 1'b0, 4'b0001, 2'd0, 4'b1111, "rot.wrap");
        step(4'b0000, 4'd0, 1'b0, 4'b0000, 2'd0, 4'b1111, "rot.end");

        // Early withdraw of ch0 after 2 grant cycles; ch1 then runs full 8 cycles
        do_reset();
        step(4'b0011, 4'd7, 1'b0, 4'b0001, 2'd0, 4'b0000, "wd.c0a");
        step(4'b0011, 4'd7, 1'b0, 4'b0001, 2'd0, 4'b0000, "wd.c0b");
        step(4'b0010, 4'd7, 1'b0, 4'b0000, 2'd0, 4'b0001, "wd.gap");
        for (int k = 0; k < 8; k++)
            step(4'b0010, 4'd7, 1'b0, 4'b0010, 2'd1, 4'b0001, "wd.c1");
        step(4'b0010, 4'd7, 1'b0, 4'b0000, 2'd1, 4'b0011, "wd.rel1");
        step(4'b0000, 4'd7, 1'b0, 4'b0000, 2'd1, 4'b0011, "wd.idle");

        // hold_len captured at grant start: 2-cycle grant, then 10-cycle grant
        do_reset();
        step(4'b0001, 4'd1, 1'b0, 4'b0001, 2'd0, 4'b0000, "hc.a0");
        step(4'b0001, 4'd9, 1'b0, 4'b0001, 2'd0, 4'b0000, "hc.a1");
        step(4'b0001, 4'd9, 1'b0, 4'b0000, 2'd0, 4'b0001, "hc.gap");
        for (int k = 0; k < 10; k++)
            step(4'b0001, 4'd9, 1'b0, 4'b0001, 2'd0, 4'b0001, "hc.b");
        step(4'b0000, 4'd9, 1'b0, 4'b0000, 2'd0, 4'b0001, "hc.rel");

        // Clear/set collision: served=1010, clear same cycle ch0 releases
        do_reset();
        step(4'b0010, 4'd0, 1'b0, 4'b0010, 2'd1, 4'b0000, "cc.g1");
        step(4'b0010, 4'd0, 1'b0, 4'b0000, 2'd1, 4'b0010, "cc.p1");
        step(4'b1000, 4'd0, 1'b0, 4'b1000, 2'd3, 4'b0010, "cc.g3");
        step(4'b1000, 4'd0, 1'b0, 4'b0000, 2'd3, 4'b1010, "cc.p3");
        step(4'b0001, 4'd0, 1'b0, 4'b0001, 2'd0, 4'b1010, "cc.g0");
        step(4'b0001, 4'd0, 1'b1, 4'b0000, 2'd0, 4'b0001, "cc.coll");
        step(4'b0000, 4'd0, 1'b0, 4'b0000, 2'd0, 4'b0001, "cc.idle");

        // Asynchronous reset mid-grant drops gnt before any clock edge
        do_reset();
        step(4'b0100, 4'd5, 1'b0, 4'b0100, 2'd2, 4'b0000, "ar.g");
        step(4'b0100, 4'd5, 1'b0, 4'b0100, 2'd2, 4'b0000, "ar.g2");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.gnt",       {4'b0, gnt},       8'h00);
        chk("arst.gnt_valid", {7'b0, gnt_valid}, 8'h00);
        chk("arst.gnt_idx",   {6'b0, gnt_idx},   8'h00);
        @(negedge clk);
        req   = '0;
        rst_n = 1'b1;

        repeat (3) @(negedge clk);
        chk("sb.drained", 8'(sb.size()), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_channel_scheduler.md
Name: rr_channel_scheduler

Overview:
- Round-robin scheduler that shares one downstream channel (mux/decoder/capture path) among NUM_CH requesters.
- Replaces free-running counter-driven selection with request-driven selection: only requesting channels get slots.
- Each grant lasts a bounded dwell time. A one-cycle gap separates consecutive grants so downstream select/enable logic settles.
- Per-channel sticky "served" flags replace level-sensitive latches with clean registered status.

Parameters:
NUM_CH, 4, number of requesters; power of two, 2..8
IDX_W, 2, log2(NUM_CH)
HOLD_W, 4, width of dwell-length field

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NUM_CH  level request per channel, held until served or withdrawn
hold_len  in  HOLD_W  max grant length minus one, in cycles; captured at grant start
served_clr  in  1  synchronous clear of all served flags
gnt  out  NUM_CH  registered one-hot grant; all-zero when idle or in gap
gnt_idx  out  IDX_W  index of current/last granted channel
gnt_valid  out  1  high exactly when gnt is non-zero
served  out  NUM_CH  sticky flag per channel, set when that channel's grant ends

Behaviour:
- Reset (async, rst_n=0): gnt=0, gnt_idx=0, gnt_valid=0, served=0, hold counter=0, state=IDLE. The last-served pointer resets to NUM_CH-1, so the first search starts at channel 0. Reset mid-grant drops gnt immediately, without waiting for a clock edge.
- States: IDLE, GRANT, GAP.
- Arbitration happens in IDLE and GAP:
  - Winner is the first asserted req scanning upward from last+1, wrapping modulo NUM_CH.
  - If a winner exists, the next state is GRANT, with gnt/gnt_idx/gnt_valid registered on the same edge.
  - Otherwise the next state is IDLE.
  - Latency from req rising (IDLE) to gnt high is 1 cycle.
- On entering GRANT: hold_len is captured into hold_lim and the hold counter is set to 0. Later hold_len changes are ignored until the next grant.
- In GRANT, release when req[gnt_idx]==0 OR counter==hold_lim. Otherwise increment the counter.
- On release (decided in cycle t):
  - served[gnt_idx] is set.
  - last pointer becomes gnt_idx.
  - state becomes GAP; gnt and gnt_valid go 0 at t+1.
  - gnt_idx keeps its value.
  - The earliest next grant is at t+2.
- Grant length is hold_len+1 cycles when the request stays high. hold_len=0 gives exactly 1-cycle grants.
- A request withdrawn on the first grant cycle still ends the grant after that 1 cycle and sets served.
- Requests from other channels during GRANT do not preempt.
- A granted channel re-requesting wins again only if no other channel requests in GAP, because the pointer has advanced past it.
- served_clr clears all flags at the next edge. If served_clr and a set occur in the same cycle, the set wins for that bit.
- gnt is always one-hot or zero; never multiple bits.
- No combinational path from req to any output; all outputs are registered.
- Fairness: with all NUM_CH requesting continuously, each channel is granted once per NUM_CH*(hold_len+2) cycles.

Test Plan:
- Reset and idle: rst_n low 3 cycles, req=0 -> gnt=0, gnt_valid=0, served=0, gnt_idx=0 throughout; assert rst_n low mid-grant -> gnt=0 within same cycle.
- Single requester: req=4'b0100 held, hold_len=2 -> gnt=0100 for 3 cycles, 1-cycle gap, repeats; gnt_idx=2; served=0100 after first release.
- Full rotation: req=4'b1111 held, hold_len=0 -> gnt sequence 0001,0,0010,0,0100,0,1000,0,0001; period 8 cycles.
- Early withdraw: req=4'b0011, hold_len=7, drop req[0] 2 cycles into grant -> ch0 grant lasts 2 cycles; gap; ch1 granted; served=0011 after ch1 release.
- Hold capture: grant starts with hold_len=1, change to 9 mid-grant -> grant lasts 2 cycles; next grant lasts 10 cycles.
- Clear collision: served=1010, assert served_clr in the same cycle ch0 releases -> served=0001 next cycle.
